idli_enc_ser_m: RTL and testbench

IDLI_ENC_SER_M -- requirements
Module: idli_enc_ser_m

---
 rtl/idli_pkg.sv | 28 ++
 rtl/idli_ser_fifo_m.sv | 65 ++++++
 rtl/idli_enc_ser_m.sv | 118 +++++++++++
 tb/tb_idli_enc_ser_m.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types and constants for the instruction-word nibble serialiser.
package idli_pkg;

    localparam int unsigned SER_DEPTH = 2;
    localparam int unsigned WORD_W    = 16;

    typedef logic [3:0] idli_nib_t;
    typedef logic [1:0] idli_idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } idli_ser_st_t;

    // Nibble 0 is the most significant nibble: the decoder needs the class field first.
    function automatic idli_nib_t get_nibble(input logic [WORD_W-1:0] word, input idli_idx_t idx);
        idli_nib_t nib;
        case (idx)
            2'd0:    nib = word[15:12];
            2'd1:    nib = word[11:8];
            2'd2:    nib = word[7:4];
            2'd3:    nib = word[3:0];
            default: nib = word[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/idli_ser_fifo_m.sv
// Two-entry in-order word buffer; exposes both the head and the entry behind it
// so the emitter can start the next word on the same edge the head pops.
module idli_ser_fifo_m
    import idli_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [1:0]        count_o,
    output logic [WORD_W-1:0] head_o,
    output logic [WORD_W-1:0] next_o
);

    logic [WORD_W-1:0] mem_q [2];
    logic              rd_ptr_q;
    logic              rd_ptr_d;
    logic              wr_ptr_q;
    logic              wr_ptr_d;
    logic [1:0]        count_q;
    logic [1:0]        count_d;

    // Pointer and occupancy next-state; flush wins over push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            rd_ptr_d = pop_i  ? ~rd_ptr_q : rd_ptr_q;
            wr_ptr_d = push_i ? ~wr_ptr_q : wr_ptr_q;
            count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[~rd_ptr_q];

endmodule

// File: rtl/idli_enc_ser_m.sv
// Serialises buffered 16-bit instruction words into MSB-first nibbles for the decoder,
// with stall hold, flush discard and a one-cycle bypass into an empty block.
module idli_enc_ser_m
    import idli_pkg::*;
#(
    parameter int unsigned SER_DEPTH = idli_pkg::SER_DEPTH
) (
    input  logic              i_ser_gck,
    input  logic              i_ser_rst_n,
    input  logic [WORD_W-1:0] i_ser_word,
    input  logic              i_ser_word_vld,
    output logic              o_ser_word_rdy,
    input  logic              i_ser_stall,
    input  logic              i_ser_flush,
    output logic [3:0]        o_ser_enc,
    output logic              o_ser_enc_vld,
    output logic              o_ser_last,
    output logic              o_ser_busy
);

    idli_ser_st_t      state_q;
    idli_idx_t         idx_q;
    idli_nib_t         enc_q;
    logic              vld_q;
    logic              last_q;

    logic              push_s;
    logic              pop_s;
    logic [1:0]        count_s;
    logic [WORD_W-1:0] head_s;
    logic [WORD_W-1:0] next_s;
    logic              avail_s;
    logic [WORD_W-1:0] src_word_s;
    idli_idx_t         nib_idx_s;

    assign o_ser_word_rdy = (count_s < 2'(SER_DEPTH));
    assign push_s         = i_ser_word_vld & o_ser_word_rdy & ~i_ser_flush;
    // The head pops on the edge after its nibble 3 is shown, independent of stall.
    assign pop_s          = last_q & ~i_ser_flush;

    idli_ser_fifo_m u_fifo (
        .clk_i       (i_ser_gck),
        .rst_n_i     (i_ser_rst_n),
        .push_i      (push_s),
        .push_data_i (i_ser_word),
        .pop_i       (pop_s),
        .flush_i     (i_ser_flush),
        .count_o     (count_s),
        .head_o      (head_s),
        .next_o      (next_s)
    );

    // Pick the word and nibble index to present at this edge; a word that
    // is popping hands over to the entry behind it, or to the bypass input.
    always_comb begin
        avail_s    = 1'b0;
        src_word_s = head_s;
        nib_idx_s  = idx_q;
        if (pop_s) begin
            nib_idx_s = 2'd0;
            if (count_s == 2'd2) begin
                avail_s    = 1'b1;
                src_word_s = next_s;
            end else if (push_s) begin
                avail_s    = 1'b1;
                src_word_s = i_ser_word;
            end else begin
                avail_s    = 1'b0;
                src_word_s = head_s;
            end
        end else begin
            nib_idx_s = idx_q;
            if (count_s != 2'd0) begin
                avail_s    = 1'b1;
                src_word_s = head_s;
            end else if (push_s) begin
                avail_s    = 1'b1;
                src_word_s = i_ser_word;
            end else begin
                avail_s    = 1'b0;
                src_word_s = head_s;
            end
        end
    end

    // Emitter FSM with registered nibble outputs; o_ser_enc holds while invalid.
    always_ff @(posedge i_ser_gck or negedge i_ser_rst_n) begin
        if (!i_ser_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            enc_q   <= 4'd0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else if (i_ser_flush || !avail_s) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else if (i_ser_stall) begin
            state_q <= ST_EMIT;
            idx_q   <= nib_idx_s;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= ST_EMIT;
            idx_q   <= nib_idx_s + 2'd1;
            enc_q   <= get_nibble(src_word_s, nib_idx_s);
            vld_q   <= 1'b1;
            last_q  <= (nib_idx_s == 2'd3);
        end
    end

    assign o_ser_enc     = enc_q;
    assign o_ser_enc_vld = vld_q;
    assign o_ser_last    = last_q;
    assign o_ser_busy    = (count_s != 2'd0) | (state_q == ST_EMIT);

endmodule

// File: tb/tb_idli_enc_ser_m.sv
// Scoreboard bench for idli_enc_ser_m: a word-level reference model predicts
// every output cycle; a negedge monitor pops expectations and compares.
module tb_idli_enc_ser_m;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_word = 16'h0000;
    logic        i_vld = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic        o_rdy;
    logic [3:0]  o_enc;
    logic        o_vld;
    logic        o_last;
    logic        o_busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    idli_enc_ser_m #(.SER_DEPTH(2)) dut (
        .i_ser_gck      (clk),
        .i_ser_rst_n    (rst_n),
        .i_ser_word     (i_word),
        .i_ser_word_vld (i_vld),
        .o_ser_word_rdy (o_rdy),
        .i_ser_stall    (i_stall),
        .i_ser_flush    (i_flush),
        .o_ser_enc      (o_enc),
        .o_ser_enc_vld  (o_vld),
        .o_ser_last     (o_last),
        .o_ser_busy     (o_busy)
    );

    always #5 clk = ~clk;

    // Reference model: words in flight, nibbles not yet shown, and the output just shown.
    logic [4:0] pend[$];
    logic [4:0] sb[$];
    int         m_cnt = 0;
    bit         m_vld = 1'b0;
    bit         m_last = 1'b0;
    logic [3:0] m_enc = 4'h0;
    bit         m_acc = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            sb.delete();
            m_cnt = 0; m_vld = 1'b0; m_last = 1'b0; m_enc = 4'h0; m_acc = 1'b0;
        end else if (i_flush) begin
            pend.delete();
            m_cnt = 0; m_vld = 1'b0; m_last = 1'b0; m_acc = 1'b0;
        end else begin
            logic [4:0] e;
            int retire;
            retire = (m_vld && m_last) ? 1 : 0;
            m_acc  = i_vld && (m_cnt < 2);
            m_cnt  = m_cnt - retire + (m_acc ? 1 : 0);
            if (m_acc) begin
                for (int k = 0; k < 4; k++) pend.push_back({(k == 3), i_word[15 - 4*k -: 4]});
            end
            if (!i_stall && pend.size() > 0) begin
                e = pend.pop_front();
                m_enc = e[3:0]; m_last = e[4]; m_vld = 1'b1;
                sb.push_back(e);
            end else begin
                m_vld = 1'b0; m_last = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            logic [4:0] e;
            chk("rdy", {15'd0, o_rdy}, {15'd0, (m_cnt < 2)});
            chk("busy", {15'd0, o_busy}, {15'd0, (m_cnt != 0)});
            chk("vld", {15'd0, o_vld}, {15'd0, m_vld});
            if (o_vld) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_nibble");
                end else begin
                    e = sb.pop_front();
                    chk("enc", {12'd0, o_enc}, {12'd0, e[3:0]});
                    chk("last", {15'd0, o_last}, {15'd0, e[4]});
                end
            end else begin
                chk("enc_hold", {12'd0, o_enc}, {12'd0, m_enc});
                chk("last_idle", {15'd0, o_last}, 16'd0);
                sb.delete();
            end
        end
    end

    task automatic idle(input int n);
        i_vld = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [15:0] w);
        bit ok;
        ok = 1'b0;
        i_vld = 1'b1; i_word = w;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = m_acc;
        end
        i_vld = 1'b0;
        if (!ok) fail_now("push_timeout");
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_vld"},  {15'd0, o_vld},  16'd0);
        chk({tag, "_last"}, {15'd0, o_last}, 16'd0);
        chk({tag, "_enc"},  {12'd0, o_enc},  16'd0);
        chk({tag, "_rdy"},  {15'd0, o_rdy},  16'd1);
        chk({tag, "_busy"}, {15'd0, o_busy}, 16'd0);
    endtask

    initial begin
        #12;
        reset_checks("rst");
        @(negedge clk); #2 rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Single word, then two back-to-back words.
        push_word(16'h1234); idle(6);
        push_word(16'hA5C3); push_word(16'h0F0F); idle(10);

        // Three words with no pops: the third waits for the first to pop.
        push_word(16'h1111); push_word(16'h2222); push_word(16'h3333); idle(14);

        // Stall at the edge after nibble 1.
        push_word(16'hBEEF);
        @(negedge clk);
        i_stall = 1'b1; @(negedge clk);
        idle(6);

        // Flush while nibble 2 is shown, one word buffered, another offered.
        push_word(16'h1357); push_word(16'h2468);
        @(negedge clk);
        i_flush = 1'b1; i_vld = 1'b1; i_word = 16'h9999;
        @(negedge clk);
        idle(6);

        // Reset in the middle of a word.
        push_word(16'hCAFE);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 reset_checks("midrst");
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        push_word(16'h00F1); idle(6);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            i_vld   = ($urandom_range(0, 99) < 70);
            i_word  = 16'($urandom);
            i_stall = ($urandom_range(0, 99) < 20);
            i_flush = ($urandom_range(0, 99) < 3);
            @(negedge clk);
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
